legv8_instr_encoder: RTL

Sequential LEGv8 instruction encoder: the inverse of the control decoder. It accepts symbolic instructions (an operation plus register and immediate fields) over a valid/ready handshake and packs them into 32-bit machine words. Each word is emitted with a sequential instruction-memory word address, so a bench or loader can fill imem for the single-cycle core. Covers exactly the decoder's subset: LDUR, STUR, CBZ, ADD, SUB, AND, ORR.

---
 rtl/legv8_instr_encoder.sv | 100 ++++++++++
 1 files changed

// File: rtl/legv8_instr_encoder.sv
// LEGv8 instruction encoder: packs symbolic ops into 32-bit words
// and tags each one with a sequential imem word address.
module legv8_instr_encoder #(
  parameter  int IMEM_DEPTH = 64,
  localparam int AW = $clog2(IMEM_DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_op,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_rn,
  input  logic [4:0]    in_rm,
  input  logic [18:0]   in_imm,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_instr,
  output logic [AW-1:0] out_addr,
  output logic          full,
  output logic          err
);

  localparam int WW = AW + 1;
  localparam logic [WW-1:0] DEPTH_W = WW'(IMEM_DEPTH);

  logic [WW-1:0] r_wptr;
  logic          r_full;
  logic          r_err;
  logic          r_out_valid;
  logic [31:0]   r_out_instr;
  logic [AW-1:0] r_out_addr;

  logic          w_acc;
  logic          w_rsv;
  logic [WW-1:0] w_wptr_nx;
  logic [31:0]   w_word;

  assign in_ready  = reset & ~clear & ~r_full
                   & (~r_out_valid | out_ready);
  assign w_acc     = in_valid & in_ready;
  assign w_rsv     = (in_op == 3'd7);
  assign w_wptr_nx = r_wptr + 1'b1;

  always_comb begin
    w_word = '0;
    case (in_op)
      3'd0: w_word = {11'b11111000010, in_imm[8:0],
                      2'b00, in_rn, in_rd};
      3'd1: w_word = {11'b11111000000, in_imm[8:0],
                      2'b00, in_rn, in_rd};
      3'd2: w_word = {8'b10110100, in_imm, in_rd};
      3'd3: w_word = {11'b10001011000, in_rm,
                      6'b000000, in_rn, in_rd};
      3'd4: w_word = {11'b11001011000, in_rm,
                      6'b000000, in_rn, in_rd};
      3'd5: w_word = {11'b10001010000, in_rm,
                      6'b000000, in_rn, in_rd};
      3'd6: w_word = {11'b10101010000, in_rm,
                      6'b000000, in_rn, in_rd};
      default: w_word = '0;
    endcase
  end

  // clear never coincides with an accept, since it forces in_ready low
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wptr      <= '0;
      r_full      <= 1'b0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_instr <= '0;
      r_out_addr  <= '0;
    end else begin
      if (clear) begin
        r_wptr <= '0;
        r_full <= 1'b0;
        r_err  <= 1'b0;
      end
      if (w_acc && !w_rsv) begin
        r_out_instr <= w_word;
        r_out_addr  <= r_wptr[AW-1:0];
        r_out_valid <= 1'b1;
        r_wptr      <= w_wptr_nx;
        r_full      <= (w_wptr_nx == DEPTH_W);
      end else begin
        if (w_acc) r_err <= 1'b1;
        if (r_out_valid && out_ready) r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_instr = r_out_instr;
  assign out_addr  = r_out_addr;
  assign full      = r_full;
  assign err       = r_err;

endmodule
